fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the pipelined vector CPU.
- Directly upstream of the hazard unit's decode/execute consumers.
- Consumes StallF, StallD and FlushD from the hazard unit, and the branch redirect from execute.
- Drives a synchronous instruction memory with 1-cycle read latency.
- Presents pc_d, instr_d and valid_d to decode, which produces RA1D/RA2D.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined vector CPU front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: default datapath widths, the decode NOP encoding, fetch hold-FSM states.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 32;
  localparam int CPU_INSTR_W = 32;

  // Instruction presented to decode when the slot is empty.
  localparam logic [CPU_INSTR_W-1:0] INSTR_NOP = '0;

  // RUN: decode sees the live memory output register.
  // HOLD: decode sees the instruction parked in holdQ during a decode stall.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID pipeline register feeding decode.
// Latency: first instruction reaches decode 1 cycle after reset release; 1 instr/cycle sustained.
// Backpressure: stall_f holds the PC, stall_d holds IF/ID (instruction parked in holdQ), flush_d empties IF/ID.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   stall_f, stall_d, flush_d     hazard-unit controls
//   branch_taken_e/_target_e      redirect from execute (beats stall_f)
//   imem_addr, imem_rd_en         synchronous instruction memory request (1-cycle read)
//   imem_rdata                    memory read data, valid the cycle after an enabled read
//   pc_d, pc_plus_d, instr_d, valid_d   decode-side IF/ID outputs
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                INSTR_W  = CPU_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               branch_taken_e,
  input  logic [ADDR_W-1:0]  branch_target_e,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc_d,
  output logic [ADDR_W-1:0]  pc_plus_d,
  output logic [INSTR_W-1:0] instr_d,
  output logic               valid_d
);

  logic [ADDR_W-1:0]  pcF;
  logic [ADDR_W-1:0]  pcD;
  logic               validD;
  logic [INSTR_W-1:0] holdQ;
  fetch_state_t       state;
  fetch_state_t       stateNext;

  // A decode stall that is not being flushed freezes the decode slot.
  logic holdReq;
  assign holdReq = stall_d && !flush_d;

  // PC register: a redirect always wins, even over a fetch stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcF <= RESET_PC;
    end else if (branch_taken_e) begin
      pcF <= branch_target_e;
    end else if (!stall_f) begin
      pcF <= pcF + PC_INC;
    end
  end

  assign imem_addr = pcF;

  // The memory output register is the instruction half of IF/ID, so a read is
  // issued exactly when the PC half is loaded; on a flush the read is harmless.
  assign imem_rd_en = !reset && (!stall_d || flush_d);

  // IF/ID PC/valid half. A flush only clears valid; the PC is left as is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcD    <= '0;
      validD <= 1'b0;
    end else if (flush_d) begin
      validD <= 1'b0;
    end else if (!stall_d) begin
      pcD    <= pcF;
      validD <= 1'b1;
    end
  end

  // Hold FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // Hold FSM: next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      RUN:     stateNext = holdReq ? HOLD : RUN;
      HOLD:    stateNext = holdReq ? HOLD : RUN;
      default: stateNext = RUN;
    endcase
  end

  // The memory is not read while decode stalls, so its output goes stale after
  // the first stall cycle; park the instruction on entry to HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdQ <= '0;
    end else if (state == RUN && holdReq) begin
      holdQ <= imem_rdata;
    end
  end

  // Hold FSM: output logic.
  always_comb begin
    instr_d = INSTR_W'(INSTR_NOP);
    if (validD) begin
      instr_d = (state == HOLD) ? holdQ : imem_rdata;
    end
  end

  assign pc_d      = pcD;
  assign valid_d   = validD;
  assign pc_plus_d = pcD + PC_INC;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata;
  logic [31:0] pc_d;
  logic [31:0] pc_plus_d;
  logic [31:0] instr_d;
  logic        valid_d;

  int errCount;
  int checkCount;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .branch_taken_e  (branch_taken_e),
    .branch_target_e (branch_target_e),
    .imem_addr       (imem_addr),
    .imem_rd_en      (imem_rd_en),
    .imem_rdata      (imem_rdata),
    .pc_d            (pc_d),
    .pc_plus_d       (pc_plus_d),
    .instr_d         (instr_d),
    .valid_d         (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word index of the address. Unread cycles return junk.
  function automatic logic [31:0] memData(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  always @(posedge clk) begin
    imem_rdata <= imem_rd_en ? memData(imem_addr) : 32'hDEAD_BEEF;
  end

  // Reference model: architectural view of the fetch PC and the decode slot.
  // Whenever the slot is valid, decode must see the memory word of its PC.
  logic [31:0] mPcF;
  logic [31:0] mPcD;
  logic        mValid;

  task automatic modelReset();
    mPcF   = 32'h0;
    mPcD   = 32'h0;
    mValid = 1'b0;
  endtask

  task automatic modelEdge();
    logic [31:0] nextPcF;
    if (reset) begin
      modelReset();
    end else begin
      nextPcF = mPcF;
      if (branch_taken_e) nextPcF = branch_target_e;
      else if (!stall_f)  nextPcF = mPcF + 32'd4;
      if (flush_d) begin
        mValid = 1'b0;
      end else if (!stall_d) begin
        mPcD   = mPcF;
        mValid = 1'b1;
      end
      mPcF = nextPcF;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: outputs checked mid-cycle, then the edge advances the model.
  task automatic step(input logic sf, input logic sd, input logic fd,
                      input logic bt, input logic [31:0] tgt, input logic rst);
    stall_f         = sf;
    stall_d         = sd;
    flush_d         = fd;
    branch_taken_e  = bt;
    branch_target_e = tgt;
    if (rst && !reset) modelReset();  // asynchronous assertion
    reset = rst;
    @(negedge clk);
    checkVal("valid_d",    {31'd0, valid_d},    {31'd0, mValid});
    checkVal("pc_d",       pc_d,                mPcD);
    checkVal("pc_plus_d",  pc_plus_d,           mPcD + 32'd4);
    checkVal("instr_d",    instr_d,             mValid ? memData(mPcD) : 32'h0);
    checkVal("imem_addr",  imem_addr,           mPcF);
    checkVal("imem_rd_en", {31'd0, imem_rd_en}, {31'd0, (!rst && (!sd || fd))});
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic stallBoth(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    errCount        = 0;
    checkCount      = 0;
    reset           = 1'b1;
    stall_f         = 1'b0;
    stall_d         = 1'b0;
    flush_d         = 1'b0;
    branch_taken_e  = 1'b0;
    branch_target_e = 32'h0;
    modelReset();
    #1;

    // Reset, then straight-line fetch.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    run(4);

    // Decode/fetch stall holds pc_d and instr_d with the memory idle.
    stallBoth(3);
    run(3);

    // Redirect with flush: one bubble, then the target.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
    run(3);

    // Flush while in HOLD beats the stall.
    stallBoth(2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    stallBoth(2);
    run(3);

    // PC wrap-around at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    run(4);

    // Reset asserted mid-HOLD, then a clean restart.
    stallBoth(2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    run(4);

    // Randomized hazard traffic.
    for (int i = 0; i < 2000; i++) begin
      logic sf, sd, fd, bt, rs;
      logic [31:0] tgt;
      sd  = ($urandom % 4) == 0;
      sf  = sd ? (($urandom % 8) != 0) : (($urandom % 16) == 0);
      fd  = ($urandom % 8) == 0;
      bt  = ($urandom % 10) == 0;
      if (bt && (($urandom % 4) != 0)) fd = 1'b1;
      tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      rs  = ($urandom % 250) == 0;
      step(sf, sd, fd, bt, tgt, rs);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
